knn_vote: RTL

Consumer of the sorter's output bundle. It accepts the sorted distance/type arrays on the valid_sort pulse and reads the first K entries, which are the K nearest neighbours. It runs a sequential majority vote over the class types and emits the winning class, its vote count, and the distance of the nearest neighbour of that class. It is the last stage of the KNN datapath, after distance_sort.

---
 rtl/knn_vote.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - sequential K-nearest-neighbour majority vote over sorted class types
module knn_vote #(
    parameter int L      = 6,
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_sort,
    input  logic [W*(1<<L)-1:0]         distance_array_sorted,
    input  logic [TYPE_W*(1<<L)-1:0]    type_array_sorted,
    output logic [TYPE_W-1:0]           class_out,
    output logic [$clog2(K+1)-1:0]      vote_count,
    output logic [W-1:0]                nearest_distance,
    output logic                        class_valid,
    output logic                        busy
);

    localparam int NT = 1 << TYPE_W;
    localparam int CW = $clog2(K + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    // Local entry storage is rounded up to a power of two so every IW-bit index is in range.
    localparam int KE = 1 << IW;

    localparam logic [IW-1:0]     LAST_I = IW'(K - 1);
    localparam logic [TYPE_W-1:0] LAST_T = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DECIDE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [TYPE_W-1:0] type_r    [KE];
    logic [W-1:0]      dist_r    [KE];
    logic [CW-1:0]     cnt       [NT];
    logic [IW-1:0]     first_idx [NT];
    logic [NT-1:0]     first_ok;

    logic [IW-1:0]     i;
    logic [TYPE_W-1:0] t;

    logic [CW-1:0]     best_cnt;
    logic [IW-1:0]     best_first;
    logic [TYPE_W-1:0] best_class;

    logic              take;
    logic [CW-1:0]     cand_cnt;
    logic [IW-1:0]     cand_first;
    logic [TYPE_W-1:0] cand_class;
    logic [TYPE_W-1:0] cur_type;

    // Entries at index K and above never take part in the vote.
    logic unused_inputs;
    assign unused_inputs = ^{distance_array_sorted, type_array_sorted};

    assign busy     = (state != IDLE);
    assign cur_type = type_r[i];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, walk K entries, then scan all NT classes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (valid_sort) begin
                    next_state = COUNT;
                end
            end
            COUNT: begin
                if (i == LAST_I) begin
                    next_state = DECIDE;
                end
            end
            DECIDE: begin
                if (t == LAST_T) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Candidate comparison for class t: more votes wins; on a tie the class seen earliest
    // in the sorted list (the one owning the nearer neighbour) wins.
    always_comb begin
        take = 1'b0;
        if (cnt[t] > best_cnt) begin
            take = 1'b1;
        end else if ((cnt[t] == best_cnt) && (cnt[t] != '0) && (first_idx[t] < best_first)) begin
            take = 1'b1;
        end
        cand_cnt   = take ? cnt[t]       : best_cnt;
        cand_first = take ? first_idx[t] : best_first;
        cand_class = take ? t            : best_class;
    end

    // Datapath: latch the K nearest entries, tally votes, track best class, publish result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < KE; j++) begin
                type_r[j] <= '0;
                dist_r[j] <= '0;
            end
            for (int c = 0; c < NT; c++) begin
                cnt[c]       <= '0;
                first_idx[c] <= '0;
            end
            first_ok         <= '0;
            i                <= '0;
            t                <= '0;
            best_cnt         <= '0;
            best_first       <= '0;
            best_class       <= '0;
            class_out        <= '0;
            vote_count       <= '0;
            nearest_distance <= '0;
            class_valid      <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_sort) begin
                        for (int j = 0; j < KE; j++) begin
                            if (j < K) begin
                                type_r[j] <= type_array_sorted[TYPE_W*j +: TYPE_W];
                                dist_r[j] <= distance_array_sorted[W*j +: W];
                            end else begin
                                type_r[j] <= '0;
                                dist_r[j] <= '0;
                            end
                        end
                        for (int c = 0; c < NT; c++) begin
                            cnt[c]       <= '0;
                            first_idx[c] <= '0;
                        end
                        first_ok   <= '0;
                        i          <= '0;
                        t          <= '0;
                        best_cnt   <= '0;
                        best_first <= '0;
                        best_class <= '0;
                    end
                end
                COUNT: begin
                    cnt[cur_type] <= cnt[cur_type] + CW'(1);
                    if (!first_ok[cur_type]) begin
                        first_idx[cur_type] <= i;
                        first_ok[cur_type]  <= 1'b1;
                    end
                    if (i == LAST_I) begin
                        t          <= '0;
                        best_cnt   <= '0;
                        best_first <= '0;
                        best_class <= '0;
                    end else begin
                        i <= i + IW'(1);
                    end
                end
                DECIDE: begin
                    best_cnt   <= cand_cnt;
                    best_first <= cand_first;
                    best_class <= cand_class;
                    t          <= t + TYPE_W'(1);
                    if (t == LAST_T) begin
                        class_out        <= cand_class;
                        vote_count       <= cand_cnt;
                        nearest_distance <= dist_r[cand_first];
                        class_valid      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
